alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Registered output stage directly downstream of the 16-bit ALU adder. It captures each ALU result (Z plus Sign, Zero, Carry, Parity, Overflow) into a small FIFO behind a valid/ready handshake, so the combinational adder is decoupled from a stalling consumer. It also maintains sticky overflow/carry status and a saturating overflow event counter for software.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CNT_W, 8, width of the overflow event counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept; equals ~full
- Z  in  16  ALU sum
- Sign, Zero, Carry, Parity, Overflow  in  1 each  ALU flags
- out_valid  out  1  head entry valid; equals ~empty
- out_ready  in  1  consumer accepts head entry
- out_z  out  16  head entry sum
- out_flags  out  5  head entry flags {Sign, Zero, Carry, Parity, Overflow}
- level  out  clog2(DEPTH)+1  current occupancy
- sticky_clr  in  1  synchronous clear of sticky status and counter
- ovf_sticky  out  1  set on any accepted entry with Overflow=1
- carry_sticky  out  1  set on any accepted entry with Carry=1
- ovf_cnt  out  CNT_W  count of accepted entries with Overflow=1, saturating

## Operation
- Entry is 21 bits: {Z, Sign, Zero, Carry, Parity, Overflow}; stored verbatim, no recomputation.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: DEPTH-entry register array, write pointer and read pointer of clog2(DEPTH) bits, wrapping modulo DEPTH. level counts 0..DEPTH.
- Full when level==DEPTH; empty when level==0.
- in_ready = ~full; not dependent on out_ready. When full, a simultaneous pop does not allow a push in the same cycle.
- When empty, no bypass: a push appears at the output the following cycle.
- push & pop in the same cycle (neither full nor empty): level unchanged, both pointers advance.
- out_z/out_flags show the entry at the read pointer, driven combinationally from storage. When empty their value is don't-care; the bench checks them only while out_valid=1.
- Upstream holds Z/flags stable while in_valid=1 and in_ready=0. Downstream holds nothing; the head is stable until popped.
- Sticky/counter, evaluated on push: ovf_sticky |= Overflow; carry_sticky |= Carry; ovf_cnt += Overflow, saturating at 2^CNT_W-1 with no wrap.
- sticky_clr has priority over a same-cycle push update. After the clear, all three are 0, and the flags of that cycle's pushed entry are not counted. The FIFO contents are unaffected.

## Timing
- Reset (async assert, sync deassert is the system's job): level=0, pointers=0, out_valid=0, in_ready=1, ovf_sticky=0, carry_sticky=0, ovf_cnt=0. Storage is not reset.
- Reset mid-operation discards all entries immediately. out_valid drops asynchronously.
- Latency: push at edge N gives out_valid=1 after edge N. Minimum input-to-output is 1 cycle.
- Throughput: 1 entry/cycle sustained while not full and the consumer is ready.
- level, in_ready, out_valid and the sticky outputs are all registered-state derived and update on the clock edge only.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Test plan
- Reset/basic: release rst_n, push Z=0x0005 flags 00000 → next cycle out_valid=1, out_z=0x0005, level=1. Pop → level=0, out_valid=0.
- Fill/full: out_ready=0, push 0x0001..0x0004 → level=4, in_ready=0. A 5th in_valid is held off. With out_ready=1 for one cycle, the pop returns 0x0001 and in_ready does not rise until the following cycle.
- Order and wrap: 10 pushes with random out_ready → pops emerge in order 0x0001..0x000A, with pointers wrapping at least twice. Concurrent push/pop keeps level constant.
- Flags passthrough: X=0x7FFF, Y=0x0001 through the ALU → entry out_z=0x8000, Sign=1, Overflow=1, Carry=0. ovf_sticky=1, carry_sticky=0, ovf_cnt=1.
- Stickies: X=0xFFFF, Y=0x0001 → out_z=0x0000, Zero=1, Carry=1, carry_sticky=1. Assert sticky_clr together with an Overflow=1 push → stickies=0, ovf_cnt=0, entry still stored. Feed 300 overflow pushes (CNT_W=8) → ovf_cnt=255.
- Async reset mid-stream: with level=3, pulse rst_n low between edges → out_valid=0 and level=0 immediately. After release, the first new push is the only entry output.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: registered output stage behind the 16-bit ALU adder.
// Captures {Z, Sign, Zero, Carry, Parity, Overflow} into a small FIFO with a
// valid/ready handshake on both sides. It also keeps sticky overflow/carry
// status and a saturating overflow event counter for software.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              Z,
  input  logic                     Sign,
  input  logic                     Zero,
  input  logic                     Carry,
  input  logic                     Parity,
  input  logic                     Overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_z,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     sticky_clr,
  output logic                     ovf_sticky,
  output logic                     carry_sticky,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              inc);
    logic [CNT_W-1:0] r;
    r = v;
    if (inc && (v != {CNT_W{1'b1}})) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

  logic [20:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             carry_sticky_q, carry_sticky_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic             full, empty, push, pop;
  logic [20:0]      head;

  // Full/empty come from registered level only, so in_ready never depends on
  // out_ready and out_valid never depends on in_valid.
  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_z     = head[20:5];
  assign out_flags = head[4:0];
  assign level     = level_q;

  assign ovf_sticky   = ovf_sticky_q;
  assign carry_sticky = carry_sticky_q;
  assign ovf_cnt      = ovf_cnt_q;

  // Next-state for pointers, occupancy and the status block.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    ovf_sticky_d   = ovf_sticky_q;
    carry_sticky_d = carry_sticky_q;
    ovf_cnt_d      = ovf_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    // A clear wins over the update from an entry accepted in the same cycle.
    if (sticky_clr) begin
      ovf_sticky_d   = 1'b0;
      carry_sticky_d = 1'b0;
      ovf_cnt_d      = '0;
    end else if (push) begin
      ovf_sticky_d   = ovf_sticky_q | Overflow;
      carry_sticky_d = carry_sticky_q | Carry;
      ovf_cnt_d      = sat_inc(ovf_cnt_q, Overflow);
    end
  end

  // Control state: async reset empties the FIFO and clears status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      ovf_sticky_q   <= 1'b0;
      carry_sticky_q <= 1'b0;
      ovf_cnt_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      ovf_sticky_q   <= ovf_sticky_d;
      carry_sticky_q <= carry_sticky_d;
      ovf_cnt_q      <= ovf_cnt_d;
    end
  end

  // Entry storage: written verbatim on push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {Z, Sign, Zero, Carry, Parity, Overflow};
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Z;
  logic [4:0]  flg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [4:0]  out_flags;
  logic [2:0]  level;
  logic        sticky_clr;
  logic        ovf_sticky;
  logic        carry_sticky;
  logic [7:0]  ovf_cnt;

  int checks;
  int errors;

  alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Z            (Z),
    .Sign         (flg[4]),
    .Zero         (flg[3]),
    .Carry        (flg[2]),
    .Parity       (flg[1]),
    .Overflow     (flg[0]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_flags    (out_flags),
    .level        (level),
    .sticky_clr   (sticky_clr),
    .ovf_sticky   (ovf_sticky),
    .carry_sticky (carry_sticky),
    .ovf_cnt      (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    Z = 16'h0; flg = 5'b0;
    #3;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({ovf_sticky, carry_sticky} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {ovf_sticky, carry_sticky}); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ovf_cnt); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; Z = 16'h0005; flg = 5'b00000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_z !== 16'h0005) begin errors++; $display("FAIL basic_z got %h exp 0005", out_z); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level got %0d exp 1", level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_pop_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; Z = 16'(i); flg = 5'b0;
      step();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d exp 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    // 5th entry held off while full
    in_valid = 1'b1; Z = 16'h0005;
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_holdoff_level got %0d exp 4", level); end
    // One pop while full: the pending push must not slip in the same cycle
    checks++; if (out_z !== 16'h0001) begin errors++; $display("FAIL fill_head got %h exp 0001", out_z); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level got %0d exp 3", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_push5_level got %0d exp 4", level); end
    // Drain and verify order 2,3,4,5
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checks++; if (out_z !== 16'(i)) begin errors++; $display("FAIL fill_drain_z got %h exp %h", out_z, 16'(i)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_order_wrap();
    logic [15:0] rdy_pat;
    int pushed, popped, cnt, cyc;
    logic do_push, do_pop;
    rdy_pat = 16'b1010_0110_0011_1001;
    pushed = 0; popped = 0; cnt = 0; cyc = 0;
    while (popped < 10 && cyc < 200) begin
      in_valid  = (pushed < 10);
      Z         = 16'(pushed + 1);
      flg       = 5'b0;
      out_ready = (pushed < 10) ? rdy_pat[cyc % 16] : 1'b1;
      #1;
      checks++; if (level !== 3'(cnt)) begin errors++; $display("FAIL order_level cyc %0d got %0d exp %0d", cyc, level, cnt); end
      checks++; if (in_ready !== (cnt != 4)) begin errors++; $display("FAIL order_in_ready cyc %0d got %b exp %b", cyc, in_ready, cnt != 4); end
      checks++; if (out_valid !== (cnt != 0)) begin errors++; $display("FAIL order_out_valid cyc %0d got %b exp %b", cyc, out_valid, cnt != 0); end
      do_push = in_valid && (cnt != 4);
      do_pop  = out_ready && (cnt != 0);
      if (do_pop) begin
        checks++; if (out_z !== 16'(popped + 1)) begin errors++; $display("FAIL order_z got %h exp %h", out_z, 16'(popped + 1)); end
        popped++;
      end
      if (do_push) pushed++;
      cnt = cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (popped != 10) begin errors++; $display("FAIL order_timeout popped %0d exp 10", popped); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; Z = 16'h0100; flg = 5'b0;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (out_z !== 16'h0100 + 16'(i - 1)) begin errors++; $display("FAIL b2b_z got %h exp %h", out_z, 16'h0100 + 16'(i - 1)); end
      Z = 16'h0100 + 16'(i);
      step();
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level got %0d exp 1", level); end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flags();
    // 0x7FFF + 0x0001 = 0x8000: Sign=1 Zero=0 Carry=0 Parity=1 Overflow=1
    in_valid = 1'b1; Z = 16'h8000; flg = 5'b10011;
    step();
    in_valid = 1'b0;
    checks++; if (out_z !== 16'h8000) begin errors++; $display("FAIL flags_z got %h exp 8000", out_z); end
    checks++; if (out_flags !== 5'b10011) begin errors++; $display("FAIL flags_flags got %b exp 10011", out_flags); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL flags_ovf_sticky got %b exp 1", ovf_sticky); end
    checks++; if (carry_sticky !== 1'b0) begin errors++; $display("FAIL flags_carry_sticky got %b exp 0", carry_sticky); end
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL flags_cnt got %0d exp 1", ovf_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_sticky();
    // 0xFFFF + 0x0001 = 0x0000: Sign=0 Zero=1 Carry=1 Parity=0 Overflow=0
    in_valid = 1'b1; Z = 16'h0000; flg = 5'b01100;
    step();
    in_valid = 1'b0;
    checks++; if (out_z !== 16'h0000) begin errors++; $display("FAIL sticky_z got %h exp 0000", out_z); end
    checks++; if (out_flags !== 5'b01100) begin errors++; $display("FAIL sticky_flags got %b exp 01100", out_flags); end
    checks++; if (carry_sticky !== 1'b1) begin errors++; $display("FAIL sticky_carry got %b exp 1", carry_sticky); end
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL sticky_cnt_hold got %0d exp 1", ovf_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // Clear together with an overflow push: clear wins, entry still stored
    in_valid = 1'b1; sticky_clr = 1'b1; Z = 16'h1234; flg = 5'b00001;
    step();
    in_valid = 1'b0; sticky_clr = 1'b0;
    checks++; if ({ovf_sticky, carry_sticky} !== 2'b00) begin errors++; $display("FAIL clr_sticky got %b exp 00", {ovf_sticky, carry_sticky}); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", ovf_cnt); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL clr_level got %0d exp 1", level); end
    checks++; if (out_z !== 16'h1234) begin errors++; $display("FAIL clr_z got %h exp 1234", out_z); end
    out_ready = 1'b1;
    step();
    // 300 overflow pushes with concurrent pops
    in_valid = 1'b1; Z = 16'h8000; flg = 5'b10011;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 200) begin
        checks++; if (ovf_cnt !== 8'd200) begin errors++; $display("FAIL sat_mid_cnt got %0d exp 200", ovf_cnt); end
      end
      if (i == 255) begin
        checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL sat_255_cnt got %0d exp 255", ovf_cnt); end
      end
    end
    in_valid = 1'b0;
    checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", ovf_cnt); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got %b exp 1", ovf_sticky); end
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL sat_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; Z = 16'h0A00 + 16'(i); flg = 5'b00001;
      step();
    end
    in_valid = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL arst_pre_level got %0d exp 3", level); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b exp 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", ovf_cnt); end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; Z = 16'hABCD; flg = 5'b0;
    step();
    in_valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL arst_new_level got %0d exp 1", level); end
    checks++; if (out_z !== 16'hABCD) begin errors++; $display("FAIL arst_new_z got %h exp abcd", out_z); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_only_entry got %b exp 0", out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_fill();
    test_order_wrap();
    test_back_to_back();
    test_flags();
    test_sticky();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
